// File: rtl/alu_exec_if.sv
// -----------------------------------------------------------------------------
// alu_exec_if
// Handshake/bus bundle between the SAP-2 control unit and the ALU execution
// unit.
//   master modport : control unit side. Drives the op request and the flag
//                    restore, and observes busy/done/result/flags.
//   slave modport  : ALU side.
// Signals:
//   start_i, op_i[3:0], a_i, b_i     op request (sampled while the ALU is idle)
//   flags_we_i, flags_i[2:0]         {C,N,Z} restore path
//   busy_o, done_o                   op in progress / one-cycle completion pulse
//   result_o                         registered result
//   flag_zero_o, flag_negative_o,
//   flag_carry_o                     Z/N/C flag register outputs
// -----------------------------------------------------------------------------
interface alu_exec_if #(
   parameter int DATA_WIDTH = 8
) ();
   logic                  start_i;
   logic [3:0]            op_i;
   logic [DATA_WIDTH-1:0] a_i;
   logic [DATA_WIDTH-1:0] b_i;
   logic                  flags_we_i;
   logic [2:0]            flags_i;
   logic                  busy_o;
   logic                  done_o;
   logic [DATA_WIDTH-1:0] result_o;
   logic                  flag_zero_o;
   logic                  flag_negative_o;
   logic                  flag_carry_o;

   modport master (
      output start_i, op_i, a_i, b_i, flags_we_i, flags_i,
      input  busy_o, done_o, result_o, flag_zero_o, flag_negative_o, flag_carry_o
   );

   modport slave (
      input  start_i, op_i, a_i, b_i, flags_we_i, flags_i,
      output busy_o, done_o, result_o, flag_zero_o, flag_negative_o, flag_carry_o
   );
endinterface

// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit
// Handshaked ALU execution unit for the SAP-2 datapath. Owns the Z/N/C flag
// register. Arithmetic/logic ops complete in one cycle; shifts and rotates run
// serially, one bit per cycle, for b_i[SHCNT_W-1:0] cycles.
// Ports:
//   clk    system clock, all state changes on posedge
//   reset  synchronous, active-high reset (aborts an op in flight, no done)
//   bus    alu_exec_if.slave: start/op/a/b request, flag restore,
//          busy/done handshake, registered result and flags
// -----------------------------------------------------------------------------
module alu_exec_unit #(
   parameter int DATA_WIDTH = 8,
   parameter int SHCNT_W    = $clog2(DATA_WIDTH)
) (
   input  logic      clk,
   input  logic      reset,
   alu_exec_if.slave bus
);
   localparam int W = DATA_WIDTH;
   localparam logic [W:0] ONE_X = {{W{1'b0}}, 1'b1};

   typedef enum logic [3:0] {
      OP_ADD = 4'h0, OP_ADC = 4'h1, OP_SUB = 4'h2, OP_SBB = 4'h3,
      OP_AND = 4'h4, OP_OR  = 4'h5, OP_XOR = 4'h6, OP_CMP = 4'h7,
      OP_INR = 4'h8, OP_DCR = 4'h9, OP_SHL = 4'hA, OP_SHR = 4'hB,
      OP_ROL = 4'hC, OP_ROR = 4'hD, OP_NOT = 4'hE, OP_PASS = 4'hF
   } op_e;

   // EXEC is the done_o cycle for every op; SHIFT iterates the serial path.
   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_SHIFT} state_e;

   state_e             state_q, state_d;
   op_e                op_q, op_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               z_q, z_d, n_q, n_d, c_q, c_d;
   logic [W-1:0]       result_q, result_d;
   logic [W-1:0]       sh_q, sh_d;
   logic [SHCNT_W-1:0] cnt_q, cnt_d;

   op_e                op_in;
   logic               is_shift_in;
   logic [SHCNT_W-1:0] cnt_in;

   assign op_in       = op_e'(bus.op_i);
   assign is_shift_in = op_in inside {OP_SHL, OP_SHR, OP_ROL, OP_ROR};
   assign cnt_in      = bus.b_i[SHCNT_W-1:0];

   // Single-cycle ALU, evaluated on the live inputs; only used on the
   // accepting edge, which is where the operands are captured.
   logic [W:0]   a_x, b_x, cin_x, alu_wide;
   logic [W-1:0] alu_res;
   logic         alu_c, alu_wr;

   always_comb begin
      // NOTE: every combinational output gets a default first, so no path
      // through the case leaves it unassigned and infers a latch.
      a_x      = {1'b0, bus.a_i};
      b_x      = {1'b0, bus.b_i};
      cin_x    = {{W{1'b0}}, c_q};
      alu_wide = a_x;
      alu_c    = c_q;
      alu_wr   = 1'b1;
      case (op_in)
         OP_ADD:  begin alu_wide = a_x + b_x;         alu_c = alu_wide[W]; end
         OP_ADC:  begin alu_wide = a_x + b_x + cin_x; alu_c = alu_wide[W]; end
         // Bit W of the wrapped difference is the unsigned borrow (a < b).
         OP_SUB:  begin alu_wide = a_x - b_x;         alu_c = alu_wide[W]; end
         OP_SBB:  begin alu_wide = a_x - b_x - cin_x; alu_c = alu_wide[W]; end
         OP_CMP:  begin alu_wide = a_x - b_x;         alu_c = alu_wide[W]; alu_wr = 1'b0; end
         OP_AND:  begin alu_wide = {1'b0, bus.a_i & bus.b_i}; alu_c = 1'b0; end
         OP_OR:   begin alu_wide = {1'b0, bus.a_i | bus.b_i}; alu_c = 1'b0; end
         OP_XOR:  begin alu_wide = {1'b0, bus.a_i ^ bus.b_i}; alu_c = 1'b0; end
         OP_INR:  alu_wide = a_x + ONE_X;
         OP_DCR:  alu_wide = a_x - ONE_X;
         OP_NOT:  alu_wide = {1'b0, ~bus.a_i};
         OP_PASS: alu_wide = b_x;
         default: ;  // shifts/rotates go through the serial path
      endcase
      alu_res = alu_wide[W-1:0];
   end

   // One step of the serial shifter on the captured operand.
   logic [W-1:0] sh_next;
   logic         sh_out;

   always_comb begin
      case (op_q)
         OP_SHL:  begin sh_next = {sh_q[W-2:0], 1'b0};      sh_out = sh_q[W-1]; end
         OP_SHR:  begin sh_next = {1'b0, sh_q[W-1:1]};      sh_out = sh_q[0];   end
         OP_ROL:  begin sh_next = {sh_q[W-2:0], sh_q[W-1]}; sh_out = sh_q[W-1]; end
         default: begin sh_next = {sh_q[0], sh_q[W-1:1]};   sh_out = sh_q[0];   end
      endcase
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      z_d      = z_q;
      n_d      = n_q;
      c_d      = c_q;
      result_d = result_q;
      sh_d     = sh_q;
      cnt_d    = cnt_q;
      case (state_q)
         S_IDLE: begin
            busy_d = 1'b0;
            // Flag restore has priority; a coincident start is dropped.
            if (bus.flags_we_i) begin
               {c_d, n_d, z_d} = bus.flags_i;
            end else if (bus.start_i) begin
               op_d   = op_in;
               busy_d = 1'b1;
               if (is_shift_in && cnt_in != '0) begin
                  state_d = S_SHIFT;
                  sh_d    = bus.a_i;
                  cnt_d   = cnt_in;
               end else begin
                  state_d = S_EXEC;
                  done_d  = 1'b1;
                  if (is_shift_in) begin
                     // Zero-count shift: pass A through, carry untouched.
                     result_d = bus.a_i;
                     z_d      = ~|bus.a_i;
                     n_d      = bus.a_i[W-1];
                  end else begin
                     if (alu_wr) result_d = alu_res;
                     z_d = ~|alu_res;
                     n_d = alu_res[W-1];
                     c_d = alu_c;
                  end
               end
            end
         end
         S_SHIFT: begin
            sh_d  = sh_next;
            cnt_d = cnt_q - SHCNT_W'(1);
            if (cnt_q == SHCNT_W'(1)) begin
               state_d  = S_EXEC;
               done_d   = 1'b1;
               result_d = sh_next;
               z_d      = ~|sh_next;
               n_d      = sh_next[W-1];
               c_d      = sh_out;
            end
         end
         default: begin  // S_EXEC: done cycle, return to idle
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge value of every other flop.
      if (reset) begin
         state_q  <= S_IDLE;
         op_q     <= OP_ADD;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         z_q      <= 1'b0;
         n_q      <= 1'b0;
         c_q      <= 1'b0;
         result_q <= '0;
         sh_q     <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         z_q      <= z_d;
         n_q      <= n_d;
         c_q      <= c_d;
         result_q <= result_d;
         sh_q     <= sh_d;
         cnt_q    <= cnt_d;
      end
   end

   assign bus.busy_o          = busy_q;
   assign bus.done_o          = done_q;
   assign bus.result_o        = result_q;
   assign bus.flag_zero_o     = z_q;
   assign bus.flag_negative_o = n_q;
   assign bus.flag_carry_o    = c_q;
endmodule
